ctr_sequencer: RTL and testbench

CTR_SEQUENCER -- requirements
Module: ctr_sequencer

---
 rtl/ctr_sequencer.sv | 117 +++++++++++
 tb/tb_ctr_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ctr_sequencer.sv
// Run sequencer for a downstream counter: holds start high for a requested number of cycles,
// checks the counter's returned value each cycle and reports pass/fail with a done pulse.
module ctr_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_len,
  input  logic             abort,
  output logic             start,
  input  logic [WIDTH-1:0] ctr_in,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, state_next;
  logic [WIDTH-1:0] len_q, len_next;
  logic [WIDTH-1:0] base, base_next;
  logic [WIDTH-1:0] idx, idx_next;
  logic [WIDTH-1:0] run_expect, drain_expect;
  logic             fail, fail_next;
  logic             mismatch, aborted;
  logic             start_next, busy_next, done_next, err_next;

  assign req_ready = (state == IDLE);

  // The counter answers one cycle late, so RUN cycle k expects base+k-1 and DRAIN base+len-1.
  assign run_expect   = base + idx - ONE;
  assign drain_expect = base + len_q - ONE;

  always_comb begin
    state_next = state;
    len_next   = len_q;
    base_next  = base;
    idx_next   = idx;
    fail_next  = fail;
    mismatch   = 1'b0;
    aborted    = 1'b0;

    case (state)
      IDLE: begin
        if (req_valid) begin
          len_next   = req_len;
          idx_next   = '0;
          fail_next  = 1'b0;
          state_next = (req_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (idx == '0) begin
          base_next = ctr_in;
        end else if (ctr_in != run_expect) begin
          mismatch = 1'b1;
        end
        idx_next = idx + ONE;
        // Comparing against len_q-1 keeps the index within WIDTH bits even for the longest run.
        if (abort) begin
          aborted    = 1'b1;
          state_next = DONE;
        end else if (idx == len_q - ONE) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (ctr_in != drain_expect) begin
          mismatch = 1'b1;
        end
        aborted    = abort;
        state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    fail_next  = fail_next | mismatch;
    start_next = (state_next == RUN);
    busy_next  = (state_next != IDLE);
    done_next  = (state_next == DONE);
    err_next   = done_next & (aborted | fail_next);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      len_q <= '0;
      base  <= '0;
      idx   <= '0;
      fail  <= 1'b0;
      start <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      len_q <= len_next;
      base  <= base_next;
      idx   <= idx_next;
      fail  <= fail_next;
      start <= start_next;
      busy  <= busy_next;
      done  <= done_next;
      err   <= err_next;
    end
  end

endmodule

// File: tb/tb_ctr_sequencer.sv
// Randomized scoreboard bench for ctr_sequencer: a driver issues runs against a counter model,
// a monitor pops the expected outcome at every done pulse.
module tb_ctr_sequencer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_len;
  logic             abort;
  logic             start;
  logic [WIDTH-1:0] ctr_in;
  logic             busy;
  logic             done;
  logic             err;

  always #5 clk = ~clk;

  ctr_sequencer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_len  (req_len),
    .abort    (abort),
    .start    (start),
    .ctr_in   (ctr_in),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // Downstream counter with one extra cycle of latency; mode 0 counts, 1 is stuck, 2 double-steps.
  logic [WIDTH-1:0] ctr;
  logic             start_d;
  logic             ctr_load;
  logic [WIDTH-1:0] ctr_load_val;
  logic [1:0]       ctr_mode;
  logic [WIDTH-1:0] step;

  assign step   = (ctr_mode == 2'd1) ? WIDTH'(0) : (ctr_mode == 2'd2) ? WIDTH'(2) : WIDTH'(1);
  assign ctr_in = ctr;

  always @(posedge clk) begin
    start_d <= start;
    if (ctr_load) ctr <= ctr_load_val;
    else if (start_d) ctr <= ctr + step;
  end

  typedef struct {
    logic err;
    int   starts;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // abort_at counts cycles after accept: 0..len-1 are RUN cycles, len is the DRAIN cycle, -1 means none.
  task automatic applyStimulus(input logic [WIDTH-1:0] len, input logic do_load,
                               input logic [WIDTH-1:0] load_val, input logic [1:0] mode,
                               input int abort_at, input logic idle_abort);
    int   waitc = 0;
    exp_t e;
    logic aborted;
    @(negedge clk);
    while (!req_ready && waitc < 600) begin
      @(negedge clk);
      waitc++;
    end
    if (!req_ready) begin
      checkOutput("ready_timeout", 32'(req_ready), 32'd1);
      return;
    end
    req_valid    = 1'b1;
    req_len      = len;
    abort        = idle_abort;
    ctr_load     = do_load;
    ctr_load_val = load_val;
    ctr_mode     = mode;

    // A correct counter never fails; stuck or double-step counters diverge once two values are compared.
    aborted  = (len != 0) && (abort_at >= 0) && (abort_at <= int'(len));
    e.err    = aborted || (mode != 2'd0 && len >= 2);
    e.starts = (len == 0) ? 0 : (aborted && abort_at < int'(len)) ? abort_at + 1 : int'(len);
    sb.push_back(e);

    @(posedge clk);
    #1;
    req_valid = 1'b0;
    abort     = 1'b0;
    ctr_load  = 1'b0;
    if (aborted) begin
      repeat (abort_at) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
    end
  endtask

  initial begin : monitor
    int   start_cnt;
    exp_t e;
    start_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
        start_cnt = 0;
      end else begin
        if (start) start_cnt++;
        if (done) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            checkOutput("err", 32'(err), 32'(e.err));
            checkOutput("start_cycles", 32'(start_cnt), 32'(e.starts));
          end
          start_cnt = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    logic [WIDTH-1:0] len;
    int               abort_at;
    int               waitc;
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_len      = '0;
    abort        = 1'b0;
    ctr_load     = 1'b1;
    ctr_load_val = '0;
    ctr_mode     = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    reset    = 1'b0;
    ctr_load = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_start", 32'(start), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);

    // Nominal, wrap-around and stuck counter runs.
    applyStimulus(8'd4, 1'b1, 8'd5, 2'd0, -1, 1'b0);
    applyStimulus(8'd3, 1'b1, 8'd254, 2'd0, -1, 1'b0);
    applyStimulus(8'd3, 1'b1, 8'd17, 2'd1, -1, 1'b0);

    // Zero length: DONE immediately with done high while ready is low.
    applyStimulus(8'd0, 1'b0, 8'd0, 2'd0, -1, 1'b0);
    @(negedge clk);
    checkOutput("zero_len_ready_low", 32'(req_ready), 32'd0);
    checkOutput("zero_len_start", 32'(start), 32'd0);
    @(negedge clk);
    checkOutput("zero_len_ready_back", 32'(req_ready), 32'd1);

    // Abort on RUN cycle 1, then a back-to-back clean run; abort on the last RUN cycle and in DRAIN.
    applyStimulus(8'd10, 1'b1, 8'd40, 2'd0, 1, 1'b0);
    @(negedge clk);
    checkOutput("abort_start_low", 32'(start), 32'd0);
    applyStimulus(8'd5, 1'b0, 8'd0, 2'd0, -1, 1'b1);
    applyStimulus(8'd3, 1'b0, 8'd0, 2'd0, 2, 1'b0);
    applyStimulus(8'd3, 1'b0, 8'd0, 2'd0, 3, 1'b0);
    applyStimulus(8'd255, 1'b1, 8'd200, 2'd0, -1, 1'b0);

    // Reset in the middle of a run drops everything with no done pulse.
    applyStimulus(8'd20, 1'b0, 8'd0, 2'd0, -1, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("midrun_reset_start", 32'(start), 32'd0);
    checkOutput("midrun_reset_busy", 32'(busy), 32'd0);
    checkOutput("midrun_reset_ready", 32'(req_ready), 32'd1);
    checkOutput("midrun_reset_done", 32'(done), 32'd0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0: len = 8'd0;
        1: len = 8'd1;
        2: len = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'd2;
        default: len = WIDTH'($urandom_range(2, 16));
      endcase
      abort_at = -1;
      if (len != 0 && $urandom_range(0, 3) == 0) abort_at = $urandom_range(0, int'(len));
      applyStimulus(len, 1'($urandom_range(0, 1)), WIDTH'($urandom),
                    2'($urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0),
                    abort_at, 1'($urandom_range(0, 3) == 0));
    end

    waitc = 0;
    @(negedge clk);
    while (!req_ready && waitc < 600) begin
      @(negedge clk);
      waitc++;
    end
    repeat (3) @(negedge clk);
    checkOutput("pending_results", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
